// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction controller.
//   bp_state_e : sequencing FSM states (RUN, FLUSH)
//   bht_ctr_t  : 2-bit saturating branch history counter
//   bht_next() : saturating train step for one counter
package branch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bp_state_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = 2'b01;
    localparam bht_ctr_t BHT_MAX   = 2'b11;
    localparam bht_ctr_t BHT_MIN   = 2'b00;

    // Move a counter one step toward the resolved outcome, clamping at the ends.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        if (taken) begin
            if (ctr == BHT_MAX) begin
                nxt = BHT_MAX;
            end else begin
                nxt = ctr + 2'b01;
            end
        end else begin
            if (ctr == BHT_MIN) begin
                nxt = BHT_MIN;
            end else begin
                nxt = ctr - 2'b01;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped table of 2-bit saturating counters.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (all entries -> weakly not-taken)
//   rd_idx      : combinational read index
//   rd_ctr      : counter at rd_idx (old value when written in the same cycle)
//   wr_en       : train the entry at wr_idx on this edge
//   wr_idx      : entry to train
//   wr_taken    : resolved outcome used to step the counter
module bht_table
    import branch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t         rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    bht_ctr_t table_r [ENTRIES];

    // Read port has no write bypass: a same-cycle write is seen next cycle.
    assign rd_ctr = table_r[rd_idx];

    // Counter storage: bulk init on reset, single-entry saturating train otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            table_r <= '{default: BHT_RESET};
        end else if (wr_en) begin
            table_r[wr_idx] <= bht_next(table_r[wr_idx], wr_taken);
        end else begin
            table_r <= table_r;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch sequencing controller between fetch and the EX branch unit.
// Predicts from a 2-bit counter table, trains it with resolved outcomes,
// sequences redirect + flush on a mispredict and keeps branch statistics.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   if_valid, if_pc    : fetch PC to predict
//   if_pred_taken      : zero-latency prediction for if_pc
//   ex_valid, ex_is_branch, ex_pc, ex_pred_taken, ex_taken, ex_target :
//                        resolved branch information from EX
//   redirect_valid     : one-cycle pulse to load redirect_pc into fetch
//   redirect_pc        : corrected fetch PC
//   flush              : kill younger IF/ID instructions
//   branch_count       : resolved branches (saturating)
//   mispredict_count   : mispredicted branches (saturating)
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int IDX_W        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    // Counter holds remaining flush cycles after the current one.
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [31:0] CNT_SAT    = 32'hFFFF_FFFF;

    bp_state_e   state_r, state_n;
    logic [3:0]  flush_cnt_r, flush_cnt_n;
    logic        redirect_valid_r, redirect_valid_n;
    logic [31:0] redirect_pc_r, redirect_pc_n;
    logic        flush_r, flush_n;
    logic [31:0] branch_cnt_r, branch_cnt_n;
    logic [31:0] mp_cnt_r, mp_cnt_n;

    logic        res_s;
    logic        mp_s;
    bht_ctr_t    rd_ctr_s;
    logic        unused_pc_bits_s;

    // Only the index bits of the fetch PC select an entry; tags are not kept.
    assign unused_pc_bits_s = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Wrong-path EX contents during FLUSH must not train or count.
    assign res_s = ex_valid & ex_is_branch & (state_r == RUN);
    assign mp_s  = res_s & (ex_pred_taken != ex_taken);

    bht_table #(
        .IDX_W (IDX_W)
    ) u_bht_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_ctr   (rd_ctr_s),
        .wr_en    (res_s),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (ex_taken)
    );

    assign if_pred_taken = if_valid ? rd_ctr_s[1] : 1'b0;

    // Next-state, redirect and flush sequencing.
    always_comb begin
        state_n          = state_r;
        flush_cnt_n      = flush_cnt_r;
        redirect_valid_n = 1'b0;
        redirect_pc_n    = redirect_pc_r;
        flush_n          = flush_r;
        case (state_r)
            RUN: begin
                if (mp_s) begin
                    state_n          = FLUSH;
                    redirect_valid_n = 1'b1;
                    redirect_pc_n    = ex_taken ? ex_target : (ex_pc + 32'd4);
                    flush_n          = 1'b1;
                    flush_cnt_n      = FLUSH_LOAD;
                end else begin
                    flush_n          = 1'b0;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == 4'd0) begin
                    state_n = RUN;
                    flush_n = 1'b0;
                end else begin
                    flush_cnt_n = flush_cnt_r - 4'd1;
                    flush_n     = 1'b1;
                end
            end
            default: begin
                state_n     = RUN;
                flush_n     = 1'b0;
                flush_cnt_n = 4'd0;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        if (res_s && (branch_cnt_r != CNT_SAT)) begin
            branch_cnt_n = branch_cnt_r + 32'd1;
        end else begin
            branch_cnt_n = branch_cnt_r;
        end
        if (mp_s && (mp_cnt_r != CNT_SAT)) begin
            mp_cnt_n = mp_cnt_r + 32'd1;
        end else begin
            mp_cnt_n = mp_cnt_r;
        end
    end

    // State and output registers; reset also aborts any flush in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= RUN;
            flush_cnt_r      <= 4'd0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
            flush_r          <= 1'b0;
            branch_cnt_r     <= 32'd0;
            mp_cnt_r         <= 32'd0;
        end else begin
            state_r          <= state_n;
            flush_cnt_r      <= flush_cnt_n;
            redirect_valid_r <= redirect_valid_n;
            redirect_pc_r    <= redirect_pc_n;
            flush_r          <= flush_n;
            branch_cnt_r     <= branch_cnt_n;
            mp_cnt_r         <= mp_cnt_n;
        end
    end

    assign redirect_valid   = redirect_valid_r;
    assign redirect_pc      = redirect_pc_r;
    assign flush            = flush_r;
    assign branch_count     = branch_cnt_r;
    assign mispredict_count = mp_cnt_r;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the table,
// the flush window and the statistics.
module tb_branch_predict_ctrl;

    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_tbl [16];
    longint      m_branches;
    longint      m_mispredicts;
    int          m_flush_left;   // flush-high cycles still to come, including current
    bit          m_rv;
    logic [31:0] m_rpc;

    branch_predict_ctrl #(
        .IDX_W        (4),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    // Apply one cycle of stimulus, check the prediction before the edge,
    // advance the model across the edge and check registered outputs after it.
    task automatic cycle(input bit rst, input bit ifv, input logic [31:0] ifpc,
                         input bit exv, input bit exb, input logic [31:0] expc,
                         input bit pt, input bit tk, input logic [31:0] tgt);
        bit in_flush;
        bit res;
        @(negedge clk);
        rst_n = ~rst; if_valid = ifv; if_pc = ifpc;
        ex_valid = exv; ex_is_branch = exb; ex_pc = expc;
        ex_pred_taken = pt; ex_taken = tk; ex_target = tgt;
        #1;
        check("pred", {31'd0, if_pred_taken}, ifv ? ((m_tbl[idx_of(ifpc)] >= 2) ? 32'd1 : 32'd0) : 32'd0);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_tbl[i] = 1;
            m_branches = 0; m_mispredicts = 0; m_flush_left = 0; m_rv = 0; m_rpc = 32'd0;
        end else begin
            in_flush = (m_flush_left > 0);
            res = exv && exb && !in_flush;
            m_rv = 0;
            if (in_flush) m_flush_left--;
            if (res) begin
                if (tk) m_tbl[idx_of(expc)] = (m_tbl[idx_of(expc)] == 3) ? 3 : m_tbl[idx_of(expc)] + 1;
                else    m_tbl[idx_of(expc)] = (m_tbl[idx_of(expc)] == 0) ? 0 : m_tbl[idx_of(expc)] - 1;
                if (m_branches < 64'hFFFF_FFFF) m_branches++;
                if (pt != tk) begin
                    if (m_mispredicts < 64'hFFFF_FFFF) m_mispredicts++;
                    m_rv = 1;
                    m_rpc = tk ? tgt : expc + 32'd4;
                    m_flush_left = FLUSH_CYCLES;
                end
            end
        end
        #1;
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
        check("redirect_pc", redirect_pc, m_rpc);
        check("flush", {31'd0, flush}, (m_flush_left > 0) ? 32'd1 : 32'd0);
        check("branch_count", branch_count, m_branches[31:0]);
        check("mispredict_count", mispredict_count, m_mispredicts[31:0]);
    endtask

    task automatic idle(input logic [31:0] ifpc);
        cycle(0, 1, ifpc, 0, 0, 32'd0, 0, 0, 32'd0);
    endtask

    task automatic branch(input logic [31:0] pc, input bit pt, input bit tk, input logic [31:0] tgt);
        cycle(0, 1, pc, 1, 1, pc, pt, tk, tgt);
    endtask

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < 16; i++) m_tbl[i] = 1;
        m_branches = 0; m_mispredicts = 0; m_flush_left = 0; m_rv = 0; m_rpc = 32'd0;
        rst_n = 1'b0; if_valid = 1'b0; if_pc = 32'd0; ex_valid = 1'b0; ex_is_branch = 1'b0;
        ex_pc = 32'd0; ex_pred_taken = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;

        // Reset and fresh-table prediction
        cycle(1, 0, 32'd0, 0, 0, 32'd0, 0, 0, 32'd0);
        cycle(1, 0, 32'd0, 0, 0, 32'd0, 0, 0, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_bcnt", branch_count, 32'd0);
        idle(32'h100);

        // Training 0x100: first taken mispredicts, then predicted correctly, saturates
        branch(32'h100, 0, 1, 32'h140);
        idle(32'h100);
        idle(32'h100);
        branch(32'h100, 1, 1, 32'h140);
        branch(32'h100, 1, 1, 32'h140);
        check("train_bcnt", branch_count, 32'd3);
        check("train_mcnt", mispredict_count, 32'd1);
        branch(32'h100, 1, 0, 32'h140);   // 11 -> 10, still predicts taken
        idle(32'h100);
        idle(32'h100);

        // Mispredict taken, with a second mispredict inside the flush window
        branch(32'h200, 0, 1, 32'h180);
        check("mp_redirect_pc", redirect_pc, 32'h180);
        check("mp_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        branch(32'h204, 1, 0, 32'h300);
        check("flush_ignored_mcnt", mispredict_count, 32'd3);
        idle(32'h200);
        check("flush_dropped", {31'd0, flush}, 32'd0);

        // Not-taken mispredict with fall-through wrap
        branch(32'hFFFF_FFFC, 1, 0, 32'h40);
        check("wrap_pc", redirect_pc, 32'h0000_0000);
        idle(32'h0);
        idle(32'h0);

        // Same index read and write in one cycle
        cycle(0, 1, 32'h300, 1, 1, 32'h300, 1, 1, 32'h0);
        idle(32'h300);

        // Reset in the second flush cycle
        branch(32'h400, 0, 1, 32'h500);
        idle(32'h0);
        cycle(1, 0, 32'd0, 0, 0, 32'd0, 0, 0, 32'd0);
        check("midflush_flush", {31'd0, flush}, 32'd0);
        check("midflush_mcnt", mispredict_count, 32'd0);
        for (int i = 0; i < 16; i++) idle(32'(i * 4));

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cycle(($urandom_range(0, 79) == 0), $urandom_range(0, 1),
                  {$urandom_range(0, 63), 2'b00} & 32'h0000_00FC,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 0) ? rpc : ({$urandom_range(0, 63), 2'b00} & 32'h0000_00FC),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
